// File: rtl/vc_fifo_pkg.sv
// Shared constants and width helpers for the virtual-channel input buffer.
package vc_fifo_pkg;

    localparam int FLIT_W = 8;

    function automatic int vcWidth(input int numVc);
        return (numVc > 1) ? $clog2(numVc) : 1;
    endfunction

    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// Write/read port bundle of the VC buffer; master drives requests, slave is the buffer.
interface vc_fifo_if
    import vc_fifo_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 8
);
    localparam int VC_W  = vcWidth(NUM_VC);
    localparam int CNT_W = cntWidth(DEPTH);

    logic                      wr_en;
    logic [VC_W-1:0]           wr_vc;
    logic [DATA_W-1:0]         data_i;
    logic                      rd_en;
    logic [VC_W-1:0]           rd_vc;
    logic [DATA_W-1:0]         data_o;
    logic [NUM_VC-1:0]         empty;
    logic [NUM_VC-1:0]         almost_full;
    logic [NUM_VC-1:0]         full;
    logic [NUM_VC*CNT_W-1:0]   count;
    logic                      ovf_err;
    logic                      udf_err;

    modport master (
        output wr_en, wr_vc, data_i, rd_en, rd_vc,
        input  data_o, empty, almost_full, full, count, ovf_err, udf_err
    );

    modport slave (
        input  wr_en, wr_vc, data_i, rd_en, rd_vc,
        output data_o, empty, almost_full, full, count, ovf_err, udf_err
    );

endinterface

// File: rtl/vc_fifo_ctrl.sv
// Per-VC pointer/occupancy bookkeeping; push and pop arrive already qualified by the top.
module vc_fifo_ctrl
    import vc_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1,
    parameter int PTR_W     = ptrWidth(DEPTH),
    parameter int CNT_W     = cntWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             full_o
);

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wrPtr_d = push_i ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = pop_i  ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign wr_ptr_o      = wrPtr_q;
    assign rd_ptr_o      = rdPtr_q;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (count_q >= CNT_W'(DEPTH - AF_MARGIN));
    assign full_o        = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC input buffer: shared storage, write/read qualification, head mux and sticky errors.
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int DATA_W    = FLIT_W,
    parameter int DEPTH     = 8,
    parameter int NUM_VC    = 2,
    parameter int AF_MARGIN = 1
) (
    input logic      clk,
    input logic      rst,
    vc_fifo_if.slave bus
);

    localparam int VC_W  = vcWidth(NUM_VC);
    localparam int CNT_W = cntWidth(DEPTH);
    localparam int PTR_W = ptrWidth(DEPTH);

    logic [DATA_W-1:0]       mem_q [NUM_VC][DEPTH];
    logic [PTR_W-1:0]        wrPtr [NUM_VC];
    logic [PTR_W-1:0]        rdPtr [NUM_VC];
    logic [CNT_W-1:0]        cntVc [NUM_VC];
    logic [NUM_VC-1:0]       emptyVec, afVec, fullVec, pushVec, popVec;
    logic [NUM_VC*CNT_W-1:0] countFlat;
    logic                    wrInRange, rdInRange, headValid, rdOk, wrOk;
    logic                    ovfErr_q, udfErr_q;

    // Range checks are only meaningful when NUM_VC leaves unused VC codes.
    if (NUM_VC == (1 << VC_W)) begin : g_fullRange
        assign wrInRange = 1'b1;
        assign rdInRange = 1'b1;
    end else begin : g_partRange
        assign wrInRange = (bus.wr_vc < VC_W'(NUM_VC));
        assign rdInRange = (bus.rd_vc < VC_W'(NUM_VC));
    end

    // A full VC still takes a write when the same VC is popped this cycle.
    assign headValid = rdInRange && !emptyVec[bus.rd_vc];
    assign rdOk      = bus.rd_en && headValid;
    assign wrOk      = bus.wr_en && wrInRange &&
                       (!fullVec[bus.wr_vc] || (rdOk && (bus.wr_vc == bus.rd_vc)));

    always_comb begin
        pushVec   = '0;
        popVec    = '0;
        countFlat = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            pushVec[v] = wrOk && (bus.wr_vc == VC_W'(v));
            popVec[v]  = rdOk && (bus.rd_vc == VC_W'(v));
            countFlat[v*CNT_W +: CNT_W] = cntVc[v];
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_ctrl #(
            .DEPTH     (DEPTH),
            .AF_MARGIN (AF_MARGIN),
            .PTR_W     (PTR_W),
            .CNT_W     (CNT_W)
        ) u_ctrl (
            .clk           (clk),
            .rst           (rst),
            .push_i        (pushVec[v]),
            .pop_i         (popVec[v]),
            .wr_ptr_o      (wrPtr[v]),
            .rd_ptr_o      (rdPtr[v]),
            .count_o       (cntVc[v]),
            .empty_o       (emptyVec[v]),
            .almost_full_o (afVec[v]),
            .full_o        (fullVec[v])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[v][e] <= '0;
                end
            end
        end else if (wrOk) begin
            mem_q[bus.wr_vc][wrPtr[bus.wr_vc]] <= bus.data_i;
        end
    end

    // Errors are sticky until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfErr_q <= 1'b0;
            udfErr_q <= 1'b0;
        end else begin
            if (bus.wr_en && !wrOk) ovfErr_q <= 1'b1;
            if (bus.rd_en && !rdOk) udfErr_q <= 1'b1;
        end
    end

    assign bus.data_o      = headValid ? mem_q[bus.rd_vc][rdPtr[bus.rd_vc]] : '0;
    assign bus.empty       = emptyVec;
    assign bus.almost_full = afVec;
    assign bus.full        = fullVec;
    assign bus.count       = countFlat;
    assign bus.ovf_err     = ovfErr_q;
    assign bus.udf_err     = udfErr_q;

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: a 2x8 build and a 3x5 build against a queue-based model.
module tb_vc_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nRun = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    vc_fifo_if #(.DATA_W(8), .NUM_VC(2), .DEPTH(8)) busA ();
    vc_fifo_if #(.DATA_W(8), .NUM_VC(3), .DEPTH(5)) busB ();

    vc_fifo #(.DATA_W(8), .DEPTH(8), .NUM_VC(2), .AF_MARGIN(1)) dutA (
        .clk (clk), .rst (rst), .bus (busA)
    );
    vc_fifo #(.DATA_W(8), .DEPTH(5), .NUM_VC(3), .AF_MARGIN(2)) dutB (
        .clk (clk), .rst (rst), .bus (busB)
    );

    // Reference model: one queue per VC per build, plus sticky error flags.
    logic [7:0] mq [2][3][$];
    bit         mOvf [2];
    bit         mUdf [2];

    function automatic int nvcOf(input int dut);   return (dut == 0) ? 2 : 3; endfunction
    function automatic int depthOf(input int dut); return (dut == 0) ? 8 : 5; endfunction
    function automatic int afOf(input int dut);    return (dut == 0) ? 1 : 2; endfunction
    function automatic int cntwOf(input int dut);  return (dut == 0) ? 4 : 3; endfunction

    function automatic void modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 3; v++) mq[d][v].delete();
            mOvf[d] = 1'b0;
            mUdf[d] = 1'b0;
        end
    endfunction

    function automatic void modelApply(input int dut, input bit we, input int wvc,
                                       input logic [7:0] d, input bit re, input int rvc);
        bit rdOk, wrOk;
        rdOk = 1'b0;
        wrOk = 1'b0;
        if (re && rvc < nvcOf(dut)) begin
            if (mq[dut][rvc].size() > 0) rdOk = 1'b1;
        end
        if (we && wvc < nvcOf(dut)) begin
            if (mq[dut][wvc].size() < depthOf(dut) || (rdOk && rvc == wvc)) wrOk = 1'b1;
        end
        if (re && !rdOk) mUdf[dut] = 1'b1;
        if (we && !wrOk) mOvf[dut] = 1'b1;
        if (rdOk) void'(mq[dut][rvc].pop_front());
        if (wrOk) mq[dut][wvc].push_back(d);
    endfunction

    function automatic logic [2:0] expEmpty(input int dut);
        logic [2:0] r = '0;
        for (int v = 0; v < nvcOf(dut); v++) r[v] = (mq[dut][v].size() == 0);
        return r;
    endfunction

    function automatic logic [2:0] expFull(input int dut);
        logic [2:0] r = '0;
        for (int v = 0; v < nvcOf(dut); v++) r[v] = (mq[dut][v].size() == depthOf(dut));
        return r;
    endfunction

    function automatic logic [2:0] expAf(input int dut);
        logic [2:0] r = '0;
        for (int v = 0; v < nvcOf(dut); v++)
            r[v] = (mq[dut][v].size() >= depthOf(dut) - afOf(dut));
        return r;
    endfunction

    function automatic logic [8:0] expCount(input int dut);
        logic [8:0] r = '0;
        for (int v = 0; v < nvcOf(dut); v++)
            r = r | (9'(mq[dut][v].size()) << (v * cntwOf(dut)));
        return r;
    endfunction

    function automatic logic [7:0] expData(input int dut, input int rvc);
        if (rvc < nvcOf(dut)) begin
            if (mq[dut][rvc].size() > 0) return mq[dut][rvc][0];
        end
        return 8'h00;
    endfunction

    // Drive one cycle on the chosen build, advance the model, return just after the edge.
    task automatic step(input int dut, input bit we, input int wvc, input logic [7:0] d,
                        input bit re, input int rvc);
        @(negedge clk);
        if (dut == 0) begin
            busA.wr_en = we; busA.wr_vc = 1'(wvc); busA.data_i = d;
            busA.rd_en = re; busA.rd_vc = 1'(rvc);
        end else begin
            busB.wr_en = we; busB.wr_vc = 2'(wvc); busB.data_i = d;
            busB.rd_en = re; busB.rd_vc = 2'(rvc);
        end
        modelApply(dut, we, wvc, d, re, rvc);
        @(posedge clk);
        #1;
        busA.wr_en = 1'b0; busA.rd_en = 1'b0;
        busB.wr_en = 1'b0; busB.rd_en = 1'b0;
    endtask

    // Reset with requests active on both builds: reset must win.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        busA.wr_en = 1'b1; busA.wr_vc = '0; busA.data_i = 8'hEE; busA.rd_en = 1'b1; busA.rd_vc = '0;
        busB.wr_en = 1'b1; busB.wr_vc = '0; busB.data_i = 8'hEE; busB.rd_en = 1'b1; busB.rd_vc = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        busA.wr_en = 1'b0; busA.rd_en = 1'b0;
        busB.wr_en = 1'b0; busB.rd_en = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        doReset();
        nRun++;
        if (busA.empty !== 2'b11 || busB.empty !== 3'b111) begin
            nFail++;
            $display("[TB] FAIL reset_empty: got A=%b B=%b want A=11 B=111", busA.empty, busB.empty);
        end
        nRun++;
        if (busA.count !== 8'h00 || busB.count !== 9'h000) begin
            nFail++;
            $display("[TB] FAIL reset_count: got A=%h B=%h want 0", busA.count, busB.count);
        end
        nRun++;
        if (busA.full !== 2'b00 || busA.almost_full !== 2'b00) begin
            nFail++;
            $display("[TB] FAIL reset_flags: got full=%b af=%b want 00 00", busA.full, busA.almost_full);
        end
        nRun++;
        if (busA.data_o !== 8'h00 || busB.data_o !== 8'h00) begin
            nFail++;
            $display("[TB] FAIL reset_data: got A=%h B=%h want 00", busA.data_o, busB.data_o);
        end
        nRun++;
        if ({busA.ovf_err, busA.udf_err, busB.ovf_err, busB.udf_err} !== 4'b0000) begin
            nFail++;
            $display("[TB] FAIL reset_err: got %b want 0000",
                     {busA.ovf_err, busA.udf_err, busB.ovf_err, busB.udf_err});
        end
    endtask

    task automatic test_fill_drain();
        doReset();
        for (int i = 1; i <= 9; i++) begin
            step(0, 1'b1, 0, 8'(i), 1'b0, 0);
            nRun++;
            if (busA.count[3:0] !== 4'((i > 8) ? 8 : i) || busA.almost_full[0] !== (i >= 7) ||
                busA.full[0] !== (i >= 8) || busA.ovf_err !== (i == 9)) begin
                nFail++;
                $display("[TB] FAIL fill_%0d: got cnt=%0d af=%b full=%b ovf=%b want cnt=%0d af=%b full=%b ovf=%b",
                         i, busA.count[3:0], busA.almost_full[0], busA.full[0], busA.ovf_err,
                         (i > 8) ? 8 : i, (i >= 7), (i >= 8), (i == 9));
            end
        end
        for (int i = 1; i <= 8; i++) begin
            busA.rd_vc = 1'b0;
            #1;
            nRun++;
            if (busA.data_o !== 8'(i) || busA.empty[1] !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL drain_%0d: got data=%h empty1=%b want data=%h empty1=1",
                         i, busA.data_o, busA.empty[1], 8'(i));
            end
            step(0, 1'b0, 0, 8'h00, 1'b1, 0);
        end
        nRun++;
        if (busA.empty !== 2'b11 || busA.udf_err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL drain_end: got empty=%b udf=%b want 11 0", busA.empty, busA.udf_err);
        end
    endtask

    task automatic test_full_wr_rd();
        logic [7:0] w [8];
        doReset();
        for (int i = 0; i < 8; i++) begin
            w[i] = 8'($urandom_range(0, 255));
            step(0, 1'b1, 0, w[i], 1'b0, 0);
        end
        step(0, 1'b1, 0, 8'hAA, 1'b1, 0);
        nRun++;
        if (busA.count[3:0] !== 4'd8 || busA.full[0] !== 1'b1 || busA.ovf_err !== 1'b0 ||
            busA.data_o !== w[1]) begin
            nFail++;
            $display("[TB] FAIL full_wrrd: got cnt=%0d full=%b ovf=%b head=%h want 8 1 0 %h",
                     busA.count[3:0], busA.full[0], busA.ovf_err, busA.data_o, w[1]);
        end
        for (int k = 1; k <= 8; k++) begin
            busA.rd_vc = 1'b0;
            #1;
            nRun++;
            if (busA.data_o !== ((k < 8) ? w[k] : 8'hAA)) begin
                nFail++;
                $display("[TB] FAIL full_drain_%0d: got %h want %h", k, busA.data_o,
                         (k < 8) ? w[k] : 8'hAA);
            end
            step(0, 1'b0, 0, 8'h00, 1'b1, 0);
        end
    endtask

    task automatic test_interleave();
        doReset();
        for (int i = 0; i < 4; i++) step(0, 1'b1, 0, 8'(8'h40 + i), 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, 1, 8'(8'h11 + i), 1'b1, 0);
            nRun++;
            if (busA.count !== {4'(i + 1), 4'(3 - i)}) begin
                nFail++;
                $display("[TB] FAIL interleave_%0d: got count=%h want %h", i, busA.count,
                         {4'(i + 1), 4'(3 - i)});
            end
        end
        busA.rd_vc = 1'b1;
        #1;
        nRun++;
        if (busA.data_o !== 8'h11 || busA.empty !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL interleave_head: got data=%h empty=%b want 11 01", busA.data_o, busA.empty);
        end
    endtask

    task automatic test_underflow();
        doReset();
        step(0, 1'b0, 0, 8'h00, 1'b1, 1);
        nRun++;
        if (busA.udf_err !== 1'b1 || busA.count !== 8'h00 || busA.empty !== 2'b11 || busA.ovf_err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL udf_empty: got udf=%b cnt=%h empty=%b ovf=%b want 1 00 11 0",
                     busA.udf_err, busA.count, busA.empty, busA.ovf_err);
        end
        step(0, 1'b1, 1, 8'h5A, 1'b1, 1);
        nRun++;
        if (busA.count !== 8'h10 || busA.data_o !== 8'h5A) begin
            nFail++;
            $display("[TB] FAIL udf_samevc: got cnt=%h data=%h want 10 5a", busA.count, busA.data_o);
        end
    endtask

    task automatic test_wrap();
        doReset();
        step(1, 1'b1, 1, 8'hC0, 1'b0, 0);
        step(1, 1'b1, 1, 8'hC1, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1'b1, 1, 8'($urandom_range(0, 255)), 1'b1, 1);
            nRun++;
            if (busB.data_o !== expData(1, 1) || busB.count !== 9'h010) begin
                nFail++;
                $display("[TB] FAIL wrap_%0d: got data=%h cnt=%h want %h 010", i, busB.data_o,
                         busB.count, expData(1, 1));
            end
        end
        step(1, 1'b1, 3, 8'h77, 1'b0, 0);
        nRun++;
        if (busB.ovf_err !== 1'b1 || busB.count !== 9'h010) begin
            nFail++;
            $display("[TB] FAIL oor_write: got ovf=%b cnt=%h want 1 010", busB.ovf_err, busB.count);
        end
        step(1, 1'b0, 0, 8'h00, 1'b1, 3);
        nRun++;
        if (busB.udf_err !== 1'b1 || busB.data_o !== 8'h00 || busB.count !== 9'h010) begin
            nFail++;
            $display("[TB] FAIL oor_read: got udf=%b data=%h cnt=%h want 1 00 010",
                     busB.udf_err, busB.data_o, busB.count);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int i = 0; i < 5; i++) step(0, 1'b1, 0, 8'(8'h60 + i), 1'b0, 0);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1, 8'(8'h70 + i), 1'b0, 0);
        step(1, 1'b1, 2, 8'h33, 1'b1, 0);
        doReset();
        nRun++;
        if (busA.empty !== 2'b11 || busA.count !== 8'h00 || busA.data_o !== 8'h00 ||
            busB.empty !== 3'b111 || busB.udf_err !== 1'b0 || busB.count !== 9'h000) begin
            nFail++;
            $display("[TB] FAIL reset_mid: got A empty=%b cnt=%h data=%h B empty=%b udf=%b cnt=%h want cleared",
                     busA.empty, busA.count, busA.data_o, busB.empty, busB.udf_err, busB.count);
        end
    endtask

    task automatic test_random(input int dut, input int cycles);
        logic [27:0] act, exp;
        int          wvc, rvc;
        bit          we, re;
        doReset();
        for (int i = 0; i < cycles; i++) begin
            we  = ($urandom_range(0, 99) < 55);
            re  = ($urandom_range(0, 99) < 50);
            wvc = $urandom_range(0, (dut == 0) ? 1 : 3);
            rvc = $urandom_range(0, (dut == 0) ? 1 : 3);
            step(dut, we, wvc, 8'($urandom_range(0, 255)), re, rvc);
            if (dut == 0)
                act = {1'b0, busA.empty, 1'b0, busA.almost_full, 1'b0, busA.full, 1'b0, busA.count,
                       busA.ovf_err, busA.udf_err, busA.data_o};
            else
                act = {busB.empty, busB.almost_full, busB.full, busB.count,
                       busB.ovf_err, busB.udf_err, busB.data_o};
            exp = {expEmpty(dut), expAf(dut), expFull(dut), expCount(dut),
                   mOvf[dut], mUdf[dut], expData(dut, rvc)};
            nRun++;
            if (act !== exp) begin
                nFail++;
                $display("[TB] FAIL rand_dut%0d_cyc%0d: got %h want %h", dut, i, act, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        busA.wr_en = 1'b0; busA.wr_vc = '0; busA.data_i = '0; busA.rd_en = 1'b0; busA.rd_vc = '0;
        busB.wr_en = 1'b0; busB.wr_vc = '0; busB.data_i = '0; busB.rd_en = 1'b0; busB.rd_vc = '0;
        modelReset();
        repeat (2) @(posedge clk);
        test_reset();
        test_fill_drain();
        test_full_wr_rd();
        test_interleave();
        test_underflow();
        test_wrap();
        test_reset_mid();
        test_random(0, 300);
        test_random(1, 300);
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
